// File: rtl/hpdmc_pkg.sv
// Shared constants for the HPDMC SDRAM controller datapaths.
// The write-path state encoding, the DQS pre/postamble lengths and the byte-lane width.
package hpdmc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PRE   = 3'd2,
    S_BURST = 3'd3,
    S_POST  = 3'd4
  } wr_state_t;

  localparam int DQS_PRE_LEN  = 1;
  localparam int DQS_POST_LEN = 1;
  localparam int BYTE_W       = 8;

endpackage

// File: rtl/hpdmc_wrpath.sv
// DDR write datapath: sequences DQS preamble, burst and postamble after a WRITE command.
// Pulls one 2*DQ_WIDTH word per ready cycle; a missing word is sent fully masked and flagged.
module hpdmc_wrpath
  import hpdmc_pkg::*;
#(
  parameter int DQ_WIDTH  = 32,
  parameter int BURST_LEN = 4,
  parameter int WR_LAT    = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    write_start,
  output logic                    busy,
  input  logic [2*DQ_WIDTH-1:0]   wr_data,
  input  logic [DQ_WIDTH/4-1:0]   wr_mask,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DQ_WIDTH-1:0]     dq_o_r,
  output logic [DQ_WIDTH-1:0]     dq_o_f,
  output logic [DQ_WIDTH/8-1:0]   dm_o_r,
  output logic [DQ_WIDTH/8-1:0]   dm_o_f,
  output logic                    dq_oe,
  output logic [DQ_WIDTH/8-1:0]   dqs_o_r,
  output logic [DQ_WIDTH/8-1:0]   dqs_o_f,
  output logic                    dqs_oe,
  input  logic                    err_clear,
  output logic                    underrun,
  output logic                    cmd_error
);

  localparam int N     = BURST_LEN / 2;
  localparam int NB    = DQ_WIDTH / BYTE_W;
  localparam int CNT_W = $clog2(N + 8);

  wr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_start) begin
          if (WR_LAT > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WR_LAT - 1);
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_PRE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_PRE: begin
        ready   = 1'b1;
        state_d = S_BURST;
        cnt_d   = CNT_W'(N - 1);
      end
      S_BURST: begin
        // The last beat's word was already fetched during the previous cycle.
        ready = (cnt_q != '0);
        if (cnt_q == '0) state_d = S_POST;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_POST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dq_o_r    <= '0;
      dq_o_f    <= '0;
      dm_o_r    <= '0;
      dm_o_f    <= '0;
      dq_oe     <= 1'b0;
      dqs_o_r   <= '0;
      dqs_oe    <= 1'b0;
      underrun  <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dqs_oe  <= (state_d == S_PRE) || (state_d == S_BURST) || (state_d == S_POST);
      dq_oe   <= (state_d == S_BURST);
      dqs_o_r <= (state_d == S_BURST) ? '1 : '0;
      if (ready && wr_valid) begin
        dq_o_r <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
        dq_o_f <= wr_data[DQ_WIDTH-1:0];
        dm_o_r <= wr_mask[2*NB-1:NB];
        dm_o_f <= wr_mask[NB-1:0];
      end else if (ready) begin
        dq_o_r <= '0;
        dq_o_f <= '0;
        dm_o_r <= '1;
        dm_o_f <= '1;
      end else begin
        dq_o_r <= '0;
        dq_o_f <= '0;
        dm_o_r <= '0;
        dm_o_f <= '0;
      end
      // Set beats clear so an event coinciding with err_clear is not lost.
      underrun  <= (underrun & ~err_clear) | (ready & ~wr_valid);
      cmd_error <= (cmd_error & ~err_clear) | (write_start & busy);
    end
  end

  assign dqs_o_f  = '0;
  assign busy     = (state_q != S_IDLE);
  assign wr_ready = ready;

endmodule

// File: tb/tb_hpdmc_wrpath.sv
// Bench for hpdmc_wrpath: timeline model of the write sequence plus directed literal checks.
// Instance A uses default parameters, instance B uses WR_LAT=0, BURST_LEN=8.
module tb_hpdmc_wrpath;

  typedef struct packed {
    logic        busy;
    logic        rdy;
    logic [31:0] dqr;
    logic [31:0] dqf;
    logic [3:0]  dmr;
    logic [3:0]  dmf;
    logic        dqoe;
    logic [3:0]  dqsr;
    logic [3:0]  dqsf;
    logic        dqsoe;
    logic        und;
    logic        cme;
  } obs_t;

  typedef struct {
    int          ph;
    logic [63:0] word;
    logic [7:0]  msk;
    bit          und;
    bit          cme;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst, ws_a, ws_b, vld, clr;
  logic [63:0] data;
  logic [7:0]  mask;
  obs_t        oa, ob;
  mdl_t        m[2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  hpdmc_wrpath dut_a (
    .sys_clk(clk), .sys_rst(rst), .write_start(ws_a), .busy(oa.busy),
    .wr_data(data), .wr_mask(mask), .wr_valid(vld), .wr_ready(oa.rdy),
    .dq_o_r(oa.dqr), .dq_o_f(oa.dqf), .dm_o_r(oa.dmr), .dm_o_f(oa.dmf), .dq_oe(oa.dqoe),
    .dqs_o_r(oa.dqsr), .dqs_o_f(oa.dqsf), .dqs_oe(oa.dqsoe),
    .err_clear(clr), .underrun(oa.und), .cmd_error(oa.cme)
  );

  hpdmc_wrpath #(.DQ_WIDTH(32), .BURST_LEN(8), .WR_LAT(0)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .write_start(ws_b), .busy(ob.busy),
    .wr_data(data), .wr_mask(mask), .wr_valid(vld), .wr_ready(ob.rdy),
    .dq_o_r(ob.dqr), .dq_o_f(ob.dqf), .dm_o_r(ob.dmr), .dm_o_f(ob.dmf), .dq_oe(ob.dqoe),
    .dqs_o_r(ob.dqsr), .dqs_o_f(ob.dqsf), .dqs_oe(ob.dqsoe),
    .err_clear(clr), .underrun(ob.und), .cmd_error(ob.cme)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ph counts cycles since the command cycle; -1 means no sequence in flight.
  task automatic model_cycle(input int id, input int L, input int N, input logic ws, input obs_t o);
    string p;
    bit act, rdy, dqsoe, dqoe;
    p = (id == 0) ? "A" : "B";
    if (rst) begin
      chk({p, ".rst_busy"}, o.busy, 0);
      chk({p, ".rst_rdy"}, o.rdy, 0);
      chk({p, ".rst_dq"}, {o.dqr, o.dqf}, 0);
      chk({p, ".rst_dm"}, {o.dmr, o.dmf}, 0);
      chk({p, ".rst_oe"}, {o.dqoe, o.dqsoe}, 0);
      chk({p, ".rst_dqs"}, {o.dqsr, o.dqsf}, 0);
      chk({p, ".rst_flags"}, {o.und, o.cme}, 0);
      m[id] = '{ph: -1, word: 64'd0, msk: 8'd0, und: 1'b0, cme: 1'b0};
      return;
    end
    act   = (m[id].ph >= 1)     && (m[id].ph <= L + 2 + N);
    rdy   = (m[id].ph >= L + 1) && (m[id].ph <= L + N);
    dqsoe = (m[id].ph >= L + 1) && (m[id].ph <= L + 2 + N);
    dqoe  = (m[id].ph >= L + 2) && (m[id].ph <= L + 1 + N);
    chk({p, ".busy"}, o.busy, act);
    chk({p, ".wr_ready"}, o.rdy, rdy);
    chk({p, ".dq_oe"}, o.dqoe, dqoe);
    chk({p, ".dqs_oe"}, o.dqsoe, dqsoe);
    chk({p, ".dqs_o_r"}, o.dqsr, dqoe ? 4'hF : 4'h0);
    chk({p, ".dqs_o_f"}, o.dqsf, 0);
    chk({p, ".dq"}, {o.dqr, o.dqf}, m[id].word);
    chk({p, ".dm"}, {o.dmr, o.dmf}, m[id].msk);
    chk({p, ".underrun"}, o.und, m[id].und);
    chk({p, ".cmd_error"}, o.cme, m[id].cme);
    if (rdy && vld)   begin m[id].word = data;  m[id].msk = mask;  end
    else if (rdy)     begin m[id].word = 64'd0; m[id].msk = 8'hFF; end
    else              begin m[id].word = 64'd0; m[id].msk = 8'h00; end
    if (clr) begin m[id].und = 1'b0; m[id].cme = 1'b0; end
    if (rdy && !vld) m[id].und = 1'b1;
    if (ws && act)   m[id].cme = 1'b1;
    if (act) begin
      m[id].ph++;
      if (m[id].ph > L + 2 + N) m[id].ph = -1;
    end else if (ws) begin
      m[id].ph = 1;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 1, 2, ws_a, oa);
    model_cycle(1, 0, 4, ws_b, ob);
  end

  task automatic step(input logic a, input logic b, input logic v,
                      input logic [63:0] d, input logic [7:0] mk, input logic c);
    @(posedge clk);
    #1;
    ws_a = a; ws_b = b; vld = v; data = d; mask = mk; clr = c;
    @(negedge clk);
  endtask

  localparam logic [63:0] W1 = 64'h11111111_22222222;
  localparam logic [63:0] W2 = 64'h33333333_44444444;

  // One default write; v3/ws3 inject an underrun or a busy command in cycle 3.
  task automatic write_seq(input bit v3, input bit ws3);
    step(1, 0, 1, W1, 0, 0);
    chk("c0_busy", oa.busy, 0);
    chk("c0_rdy", oa.rdy, 0);
    step(0, 0, 1, W1, 0, 0);
    chk("c1_busy", oa.busy, 1);
    chk("c1_dqs_oe", oa.dqsoe, 0);
    step(0, 0, 1, W1, 0, 0);
    chk("c2_rdy", oa.rdy, 1);
    chk("c2_dqs_oe", oa.dqsoe, 1);
    chk("c2_dq_oe", oa.dqoe, 0);
    step(ws3, 0, v3, W2, 0, 0);
    chk("c3_rdy", oa.rdy, 1);
    chk("c3_dq_r", oa.dqr, 32'h11111111);
    chk("c3_dq_f", oa.dqf, 32'h22222222);
    chk("c3_dm", {oa.dmr, oa.dmf}, 0);
    chk("c3_dq_oe", oa.dqoe, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("c4_rdy", oa.rdy, 0);
    chk("c4_dq_r", oa.dqr, v3 ? 32'h33333333 : 32'h0);
    chk("c4_dq_f", oa.dqf, v3 ? 32'h44444444 : 32'h0);
    chk("c4_dm_r", oa.dmr, v3 ? 4'h0 : 4'hF);
    chk("c4_dm_f", oa.dmf, v3 ? 4'h0 : 4'hF);
    chk("c4_underrun", oa.und, !v3);
    chk("c4_cmd_error", oa.cme, ws3);
    step(0, 0, 1, 0, 0, 0);
    chk("c5_dq_oe", oa.dqoe, 0);
    chk("c5_dqs_oe", oa.dqsoe, 1);
    chk("c5_busy", oa.busy, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("c6_busy", oa.busy, 0);
    chk("c6_dqs_oe", oa.dqsoe, 0);
    chk("c6_underrun", oa.und, !v3);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("clr_flags", {oa.und, oa.cme}, 0);
  endtask

  initial begin
    rst = 1'b1; ws_a = 0; ws_b = 0; vld = 0; clr = 0; data = 0; mask = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_outs", {oa.busy, oa.dqoe, oa.dqsoe, oa.und, oa.cme}, 0);
    rst = 1'b0;
    step(0, 0, 1, 0, 0, 0);

    write_seq(1, 0);   // single write
    write_seq(0, 0);   // underrun
    write_seq(1, 1);   // command while busy

    // reset asserted mid-cycle 3 of a burst
    step(1, 0, 1, W1, 0, 0);
    step(0, 0, 1, W1, 0, 0);
    step(0, 0, 1, W1, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_oe", {oa.dqoe, oa.dqsoe}, 0);
    chk("rst_mid_busy", oa.busy, 0);
    chk("rst_mid_dq", {oa.dqr, oa.dqf}, 0);
    chk("rst_mid_rdy", oa.rdy, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 1, 0, 0, 0);
    write_seq(1, 0);

    // instance B: WR_LAT=0, four beats
    for (int c = 0; c <= 8; c++) begin
      step(0, c == 0, 1, {32'hA0000000 + 32'(c), 32'hB0000000 + 32'(c)}, (c == 3) ? 8'h5A : 8'h00, 0);
      if (c == 1) begin
        chk("b_pre_rdy", ob.rdy, 1);
        chk("b_pre_dqs_oe", ob.dqsoe, 1);
        chk("b_pre_dq_oe", ob.dqoe, 0);
      end
      if (c >= 2 && c <= 5) chk("b_burst_dq_oe", ob.dqoe, 1);
      if (c == 2) chk("b_beat0_dq_r", ob.dqr, 32'hA0000001);
      if (c == 4) begin
        chk("b_beat2_dm", {ob.dmr, ob.dmf}, 8'h5A);
        chk("b_c4_rdy", ob.rdy, 1);
      end
      if (c == 5) chk("b_c5_rdy", ob.rdy, 0);
      if (c == 6) chk("b_post", {ob.dqoe, ob.dqsoe, ob.busy}, 3'b011);
      if (c == 7) chk("b_idle_busy", ob.busy, 0);
    end

    // back-to-back at minimum spacing on instance A
    for (int c = 0; c <= 13; c++) begin
      step(c == 0 || c == 6, 0, 1, {32'hC0000000 + 32'(c), 32'hD0000000 + 32'(c)}, 0, 0);
      if (c == 6) chk("b2b_c6", {oa.dqsoe, oa.busy}, 0);
      if (c == 8) chk("b2b_c8_dqs_oe", oa.dqsoe, 1);
      if (c == 9) chk("b2b_c9_dq_r", oa.dqr, 32'hC0000008);
      if (c == 13) chk("b2b_end", {oa.cme, oa.busy}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
